// File: rtl/axis_frame_arbiter_if.sv
// Bundle of N parallel AXI-Stream video channels (tuser = SOF, tlast = EOL).
// The master drives payload/valid, the slave drives ready.
interface axis_frame_arbiter_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 32
);
    logic [N*DATA_WIDTH-1:0] tdata;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tready;
    logic [N-1:0]            tlast;
    logic [N-1:0]            tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_arbiter.sv
// Round-robin arbiter that shares one AXI-Stream video output between NUM_SRC
// sources at whole-frame granularity; the granted source is passed through combinationally.
module axis_frame_arbiter #(
    parameter int  DATA_WIDTH      = 32,
    parameter int  NUM_SRC         = 2,
    parameter int  LINES_PER_FRAME = 4,
    localparam int GW              = $clog2(NUM_SRC),
    localparam int LCW             = $clog2(LINES_PER_FRAME + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_frame_arbiter_if.slave   s_axis,
    axis_frame_arbiter_if.master  m_axis,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic                  frame_done
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [GW-1:0]    rr_ptr;
    logic [LCW-1:0]   line_cnt;
    logic [NUM_SRC-1:0] req;
    logic             pick_vld;
    logic [GW-1:0]    pick_id;
    logic             beat, eol_beat, frame_end;

    assign req = s_axis.tvalid & s_axis.tuser;

    // Scan downwards so the requester closest to rr_ptr is the one left standing.
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = GW'(idx);
            end
        end
    end

    always_comb begin
        m_axis.tdata  = '0;
        m_axis.tvalid = '0;
        m_axis.tlast  = '0;
        m_axis.tuser  = '0;
        s_axis.tready = '0;
        if (state == GRANT) begin
            m_axis.tdata            = s_axis.tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
            m_axis.tvalid           = s_axis.tvalid[grant_id];
            m_axis.tlast            = s_axis.tlast[grant_id];
            m_axis.tuser            = s_axis.tuser[grant_id];
            s_axis.tready[grant_id] = m_axis.tready[0];
        end
    end

    assign beat      = m_axis.tvalid[0] & m_axis.tready[0];
    assign eol_beat  = beat & m_axis.tlast[0];
    assign frame_end = (state == GRANT) && eol_beat &&
                       (line_cnt == LCW'(LINES_PER_FRAME - 1));
    assign busy      = (state == GRANT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld)  state_nxt = GRANT;
            GRANT:   if (frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            rr_ptr     <= '0;
            line_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_end;
            if (state == IDLE) begin
                line_cnt <= '0;
                if (pick_vld) grant_id <= pick_id;
            end else if (frame_end) begin
                line_cnt <= '0;
                rr_ptr   <= (int'(grant_id) == NUM_SRC - 1) ? '0 : grant_id + 1'b1;
            end else if (eol_beat) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench: frames are queued on per-source drivers, expected beats are queued
// in the order the round-robin should grant them and compared at the output.
module tb_axis_frame_arbiter;
    localparam int DW  = 32;
    localparam int NS  = 2;
    localparam int LPF = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic          fin;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:0]  grant_id;
    logic        busy, frame_done;

    axis_frame_arbiter_if #(.N(NS), .DATA_WIDTH(DW)) s_axis ();
    axis_frame_arbiter_if #(.N(1),  .DATA_WIDTH(DW)) m_axis ();

    axis_frame_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .LINES_PER_FRAME(LPF)) dut (
        .clk(clk), .rst_n(rst_n), .s_axis(s_axis), .m_axis(m_axis),
        .grant_id(grant_id), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    beat_t     src_q[NS][$];
    beat_t     exp_q[$];
    logic [NS-1:0] hs = '0;
    logic      bp_en = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int        cyc = 0;
    int        n_chk = 0, n_err = 0;
    logic      fd_exp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // n_src beats go to the source, n_exp of them are expected out; beat 0 is driven
    // with sof_drv (the bench may raise it later), beat 8 optionally carries a mid-frame SOF.
    task automatic push_frame(input int src, input int fr, input int n_src, input int n_exp,
                              input bit mid_sof, input bit sof_drv);
        beat_t b;
        for (int i = 0; i < n_src; i++) begin
            b.data = {8'(src), 8'(fr), 16'(i)};
            b.last = (i % LPF) == (LPF - 1);
            b.fin  = (i == 4 * LPF - 1);
            b.user = (i == 0) ? sof_drv : (mid_sof && i == 8);
            src_q[src].push_back(b);
            b.user = (i == 0) || (mid_sof && i == 8);
            if (i < n_exp) exp_q.push_back(b);
        end
    endtask

    task automatic drain(input int settle);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk); #2;
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 0);
        repeat (settle) @(negedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
    endtask

    // Source drivers: hold the head beat until it handshakes, then advance.
    initial begin
        s_axis.tdata  = '0;
        s_axis.tvalid = '0;
        s_axis.tlast  = '0;
        s_axis.tuser  = '0;
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < NS; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                hs[i] = 1'b0;
                if (src_q[i].size() > 0) begin
                    s_axis.tvalid[i]         = 1'b1;
                    s_axis.tdata[i*DW +: DW] = src_q[i][0].data;
                    s_axis.tlast[i]          = src_q[i][0].last;
                    s_axis.tuser[i]          = src_q[i][0].user;
                end else begin
                    s_axis.tvalid[i] = 1'b0;
                    s_axis.tlast[i]  = 1'b0;
                    s_axis.tuser[i]  = 1'b0;
                end
            end
            m_axis.tready = bp_en ? bp_pat[cyc % 4] : 1'b1;
        end
    end

    // Output monitor / scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fd_exp = 1'b0;
                hs     = '0;
            end else begin
                for (int i = 0; i < NS; i++) hs[i] = s_axis.tvalid[i] & s_axis.tready[i];
                if (frame_done || fd_exp) chk("frame_done", 64'(frame_done), 64'(fd_exp));
                if (fd_exp) chk("busy_after_frame", 64'(busy), 0);
                fd_exp = 1'b0;
                if (m_axis.tvalid[0] && m_axis.tready[0]) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 64'(m_axis.tdata), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {m_axis.tdata, m_axis.tlast, m_axis.tuser},
                            {e.data, e.last, e.user});
                        chk("grant_id", 64'(grant_id), 64'(e.data[31:24]));
                        chk("tready_onehot", 64'(s_axis.tready), 64'(1) << e.data[31:24]);
                        fd_exp = e.fin;
                    end
                end
            end
        end
    end

    initial begin
        #7;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_frame_done", 64'(frame_done), 0);
        chk("rst_tready", 64'(s_axis.tready), 0);
        chk("rst_mvalid", 64'(m_axis.tvalid), 0);
        chk("rst_grant", 64'(grant_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;

        // Single source, one frame.
        push_frame(0, 1, 16, 16, 1'b0, 1'b1);
        drain(3);

        // Contention from reset: expect grants 0, 1, 0.
        pulse_reset();
        push_frame(0, 2, 16, 16, 1'b0, 1'b1);
        push_frame(1, 3, 16, 16, 1'b0, 1'b1);
        push_frame(0, 4, 16, 0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            exp_q.push_back('{data: {8'd0, 8'd4, 16'(i)}, last: (i % LPF) == LPF - 1,
                              user: i == 0, fin: i == 15});
        drain(3);

        // Backpressure with ready pattern 1,0,0,1.
        bp_en = 1'b1;
        push_frame(1, 5, 16, 16, 1'b0, 1'b1);
        drain(3);
        bp_en = 1'b0;

        // Non-SOF valid beat from source 1 must stall in IDLE.
        push_frame(1, 6, 16, 16, 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk); #2;
            chk("stall_busy", 64'(busy), 0);
            chk("stall_tready1", 64'(s_axis.tready[1]), 0);
        end
        src_q[1][0].user = 1'b1;
        @(negedge clk); #2;
        chk("sof_not_yet_granted", 64'(busy), 0);
        @(negedge clk); #2;
        chk("sof_granted_busy", 64'(busy), 1);
        chk("sof_granted_id", 64'(grant_id), 1);
        drain(3);

        // Mid-frame reset after two lines of source 0.
        push_frame(0, 7, 9, 8, 1'b0, 1'b1);
        drain(0);
        rst_n = 1'b0;
        #1;
        chk("mrst_mvalid", 64'(m_axis.tvalid), 0);
        chk("mrst_tdata", 64'(m_axis.tdata), 0);
        chk("mrst_tlast_tuser", {m_axis.tlast, m_axis.tuser}, 0);
        chk("mrst_tready", 64'(s_axis.tready), 0);
        chk("mrst_busy", 64'(busy), 0);
        chk("mrst_grant", 64'(grant_id), 0);
        src_q[0].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
        push_frame(1, 8, 16, 16, 1'b0, 1'b1);
        drain(3);

        // Mid-frame SOF on line 3 is passed through; frame still ends after 4 EOLs.
        push_frame(0, 9, 16, 16, 1'b1, 1'b1);
        drain(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/axis_frame_arbiter.md
# axis_frame_arbiter

Shares one AXI-Stream video output between `NUM_SRC` AXI-Stream sources at whole-frame granularity, so frames from different sources are never interleaved.
- Upstream: per-source pixel pipelines.
- Downstream: the AXI-Stream master stage.
- Sideband convention: `tuser` marks start of frame (SOF); `tlast` marks end of line (EOL).
- A source is granted only when it presents an SOF beat, and keeps the grant until `LINES_PER_FRAME` EOL beats have been transferred.
- Arbitration between requesting sources is round-robin.

## Interface
- `DATA_WIDTH`, 32: width of `tdata` per stream.
- `NUM_SRC`, 2: number of source streams (2..8).
- `LINES_PER_FRAME`, 4: EOL beats per frame (≥1).
- `clk`  in  1: single clock; all logic rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `s_axis_tdata`  in  `NUM_SRC*DATA_WIDTH`: source data; source i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tvalid`  in  `NUM_SRC`: per-source valid.
- `s_axis_tready`  out  `NUM_SRC`: per-source ready.
- `s_axis_tlast`  in  `NUM_SRC`: per-source EOL.
- `s_axis_tuser`  in  `NUM_SRC`: per-source SOF.
- `m_axis_tdata`  out  `DATA_WIDTH`: output data.
- `m_axis_tvalid`  out  1: output valid.
- `m_axis_tready`  in  1: output ready.
- `m_axis_tlast`  out  1: output EOL.
- `m_axis_tuser`  out  1: output SOF.
- `grant_id`  out  `$clog2(NUM_SRC)`: index of the granted source; holds its last value in IDLE.
- `busy`  out  1: high while in GRANT.
- `frame_done`  out  1: one-cycle pulse when a frame completes.

## Operation
- **Request definition:** source i requests when `s_axis_tvalid[i] && s_axis_tuser[i]`.
  - A valid beat without SOF from a non-granted source is stalled (`tready` = 0), never dropped.
- **States:** IDLE, GRANT.
- **IDLE:**
  - All `s_axis_tready` = 0; `m_axis_tvalid` = 0; `m_axis_tdata`/`tlast`/`tuser` = 0.
  - If any request exists, select the first requester at or after `rr_ptr` (wrapping modulo `NUM_SRC`).
  - Register the selection into `grant_id`, clear `line_cnt`, go to GRANT.
- **GRANT** (combinational passthrough for source g = `grant_id`):
  - `m_axis_tdata/tvalid/tlast/tuser` = source g's signals.
  - `s_axis_tready[g]` = `m_axis_tready`; all other `s_axis_tready` = 0.
- **Beat accounting:**
  - A beat is a handshake: `m_axis_tvalid && m_axis_tready`.
  - A beat with `tlast` = 1 increments `line_cnt`, which is `$clog2(LINES_PER_FRAME+1)` bits wide.
- **Frame completion:**
  - A beat with `tlast` = 1 while `line_cnt == LINES_PER_FRAME-1` completes the frame.
  - At the next edge: state → IDLE, `frame_done` = 1 for one cycle, `rr_ptr` = (g+1) mod `NUM_SRC`, `line_cnt` = 0.
- **Mid-frame SOF:** an SOF beat from the granted source is passed through unchanged and has no effect on `line_cnt` or on the grant.
- **Unchanged inputs:** `rr_ptr` changes only on frame completion. Requests from other sources during GRANT are ignored until IDLE.
- **Reset** (asynchronous, at any time, including mid-frame):
  - state = IDLE, `rr_ptr` = 0, `line_cnt` = 0, `grant_id` = 0.
  - `busy` = 0, `frame_done` = 0, all `s_axis_tready` = 0, `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `m_axis_tlast` = 0, `m_axis_tuser` = 0.
  - The partial frame is abandoned; there is no recovery beyond a fresh SOF.

## Timing
- **Arbitration latency:** a request at cycle N (state IDLE) gives `busy` = 1 and `s_axis_tready[g]` = `m_axis_tready` at cycle N+1. The first beat can transfer at N+1.
- **Passthrough:** zero-latency combinational from source g to output in GRANT. No data registers and no bubbles inside a frame.
- **Frame boundary:**
  - The final EOL beat transfers at cycle M.
  - At M+1: IDLE, `frame_done` = 1, `busy` = 0.
  - The earliest next-frame beat is at M+2, giving one idle cycle between frames.
- **Backpressure:** `m_axis_tready` = 0 holds all output signals stable (source obligation); `line_cnt` does not change.
- **Simultaneous requests:** resolved in a single cycle by round-robin from `rr_ptr`. No source waits longer than `NUM_SRC-1` frames.
- **`LINES_PER_FRAME` = 1:** the first EOL beat completes the frame.

## Test plan
- **Single source:** `NUM_SRC`=2, `LINES_PER_FRAME`=4, 4 beats/line.
  - Source 0 sends 1 frame (SOF on beat 0).
  - Required: 16 beats out in order; `tuser` only on beat 0; `frame_done` 1 cycle after beat 16; `s_axis_tready[1]` = 0 throughout.
- **Contention and round-robin:** both sources hold SOF in IDLE after reset.
  - Required: source 0 granted first; after its 4 lines, source 1 is granted; then source 0 again (`grant_id` sequence 0,1,0).
- **Backpressure:**
  - Stimulus: `m_axis_tready` toggles 1,0,0,1 during a frame.
  - Required: no lost or duplicated beats; `line_cnt` advances only on handshakes; beat count = 16.
- **Non-SOF stall:**
  - Stimulus: source 1 presents `tvalid`=1, `tuser`=0 in IDLE.
  - Required: no grant, `s_axis_tready[1]` = 0, `busy` = 0 indefinitely. Raising `tuser` → grant the next cycle.
- **Mid-frame reset:**
  - Stimulus: `rst_n` low after line 2 of source 0.
  - Required: all outputs at reset values immediately. After release, source 1's SOF is granted (`rr_ptr`=0, source 0 idle), and its `line_cnt` restarts at 0.
- **Mid-frame SOF:**
  - Stimulus: granted source asserts `tuser` on line 3.
  - Required: passed through; frame still ends after the 4th EOL.
